// File: rtl/mult_accum_if.sv
// Bus between the seqmult product stream / frame control and the accumulator.
// The producer side (multiplier + controller) uses master; the accumulator uses slave.
interface mult_accum_if #(
  parameter int PW    = 8,
  parameter int ACC_W = 12,
  parameter int CNT_W = 3
);
  logic [PW-1:0]    op_in;
  logic             ready_in;
  logic             start;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output op_in, ready_in, start,
    input  acc_out, count, busy, done, ovf
  );

  modport slave (
    input  op_in, ready_in, start,
    output acc_out, count, busy, done, ovf
  );
endinterface

// File: rtl/mult_accum.sv
// Frame accumulator for the sequential multiplier: sums COUNT_N products,
// one per rising edge of the multiplier's ready level, with sticky overflow.
module mult_accum #(
  parameter int PW      = 8,
  parameter int ACC_W   = 12,
  parameter int COUNT_N = 4,
  parameter int CNT_W   = 3
) (
  input  logic         clk,
  input  logic         rst_a,
  mult_accum_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N - 1);

  logic [1:0]       state_q, state_d;
  logic             ready_dly_q, ready_dly_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic             rise;
  logic [ACC_W:0]   sum;

  assign rise = bus.ready_in & ~ready_dly_q;
  assign sum  = {1'b0, acc_q} + (ACC_W+1)'(bus.op_in);

  // Next-state logic: a start clears the frame from IDLE or DONE; in ACCUM only ready rises matter.
  always_comb begin
    state_d     = state_q;
    ready_dly_d = bus.ready_in;
    acc_d       = acc_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (rise) begin
          acc_d   = sum[ACC_W-1:0];
          count_d = count_q + CNT_W'(1);
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
          end
          if (count_q == LAST_CNT) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register all state and outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q     <= ST_IDLE;
      ready_dly_q <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_dly_q <= ready_dly_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.acc_out = acc_q;
  assign bus.count   = count_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: default frame instance plus an 8-bit, 2-product instance.
module tb_mult_accum;

  logic clk;
  logic rst_a;
  int   checks;
  int   errors;

  mult_accum_if #(.PW(8), .ACC_W(12), .CNT_W(3)) bus0 ();
  mult_accum_if #(.PW(8), .ACC_W(8),  .CNT_W(3)) bus1 ();

  mult_accum #(.PW(8), .ACC_W(12), .COUNT_N(4), .CNT_W(3)) u0 (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus0)
  );

  mult_accum #(.PW(8), .ACC_W(8), .COUNT_N(2), .CNT_W(3)) u1 (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus1)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs set afterwards are sampled at the next edge, outputs read here reflect this edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    bus0.op_in = '0; bus0.ready_in = 1'b0; bus0.start = 1'b0;
    bus1.op_in = '0; bus1.ready_in = 1'b0; bus1.start = 1'b0;
    step();
    step();
    checks++;
    if ({bus0.acc_out, bus0.count, bus0.busy, bus0.done, bus0.ovf} !== 17'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got acc=%0d cnt=%0d busy=%b done=%b ovf=%b want all 0",
               bus0.acc_out, bus0.count, bus0.busy, bus0.done, bus0.ovf);
    end
    #2 rst_a = 1'b1;
    step();
  endtask

  task automatic test_basic_frame();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    checks++;
    if (bus0.busy !== 1'b1 || bus0.acc_out !== 12'd0 || bus0.count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL start_clear got busy=%b acc=%0d cnt=%0d want busy=1 acc=0 cnt=0",
               bus0.busy, bus0.acc_out, bus0.count);
    end
    for (int i = 1; i <= 4; i++) begin
      bus0.op_in = 8'd7;
      bus0.ready_in = 1'b1;
      step();
      checks++;
      if (bus0.acc_out !== 12'(7 * i) || bus0.count !== 3'(i)) begin
        errors++;
        $display("[TB] FAIL basic_acc_%0d got acc=%0d cnt=%0d want acc=%0d cnt=%0d",
                 i, bus0.acc_out, bus0.count, 7 * i, i);
      end
      bus0.ready_in = 1'b0;
      step();
    end
    checks++;
    if (bus0.done !== 1'b1 || bus0.busy !== 1'b0 || bus0.ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done got done=%b busy=%b ovf=%b want done=1 busy=0 ovf=0",
               bus0.done, bus0.busy, bus0.ovf);
    end
  endtask

  task automatic test_long_pulse();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus0.op_in = 8'd225;
      bus0.ready_in = 1'b1;
      for (int c = 0; c < 5; c++) step();
      checks++;
      if (bus0.count !== 3'(i) || bus0.acc_out !== 12'(225 * i)) begin
        errors++;
        $display("[TB] FAIL long_pulse_%0d got cnt=%0d acc=%0d want cnt=%0d acc=%0d",
                 i, bus0.count, bus0.acc_out, i, 225 * i);
      end
      bus0.ready_in = 1'b0;
      step();
    end
    checks++;
    if (bus0.acc_out !== 12'd900 || bus0.ovf !== 1'b0 || bus0.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL long_pulse_end got acc=%0d ovf=%b done=%b want acc=900 ovf=0 done=1",
               bus0.acc_out, bus0.ovf, bus0.done);
    end
  endtask

  task automatic test_overflow();
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    bus1.op_in = 8'd200;
    bus1.ready_in = 1'b1;
    step();
    bus1.ready_in = 1'b0;
    checks++;
    if (bus1.acc_out !== 8'd200 || bus1.ovf !== 1'b0 || bus1.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_first got acc=%0d ovf=%b done=%b want acc=200 ovf=0 done=0",
               bus1.acc_out, bus1.ovf, bus1.done);
    end
    step();
    bus1.op_in = 8'd100;
    bus1.ready_in = 1'b1;
    step();
    bus1.ready_in = 1'b0;
    checks++;
    if (bus1.acc_out !== 8'd44 || bus1.ovf !== 1'b1 || bus1.done !== 1'b1 || bus1.count !== 3'd2) begin
      errors++;
      $display("[TB] FAIL ovf_wrap got acc=%0d ovf=%b done=%b cnt=%0d want acc=44 ovf=1 done=1 cnt=2",
               bus1.acc_out, bus1.ovf, bus1.done, bus1.count);
    end
    step();
    checks++;
    if (bus1.ovf !== 1'b1 || bus1.acc_out !== 8'd44) begin
      errors++;
      $display("[TB] FAIL ovf_sticky got ovf=%b acc=%0d want ovf=1 acc=44", bus1.ovf, bus1.acc_out);
    end
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    checks++;
    if (bus1.acc_out !== 8'd0 || bus1.ovf !== 1'b0 || bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_restart got acc=%0d ovf=%b busy=%b done=%b want acc=0 ovf=0 busy=1 done=0",
               bus1.acc_out, bus1.ovf, bus1.busy, bus1.done);
    end
  endtask

  task automatic test_midframe_reset();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus0.op_in = 8'd25;
      bus0.ready_in = 1'b1;
      step();
      bus0.ready_in = 1'b0;
      step();
    end
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    checks++;
    if (bus0.acc_out !== 12'd50 || bus0.count !== 3'd2 || bus0.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_accum got acc=%0d cnt=%0d busy=%b want acc=50 cnt=2 busy=1",
               bus0.acc_out, bus0.count, bus0.busy);
    end
    #2 rst_a = 1'b0;
    #1;
    checks++;
    if ({bus0.acc_out, bus0.count, bus0.busy, bus0.done, bus0.ovf} !== 17'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got acc=%0d cnt=%0d busy=%b done=%b ovf=%b want all 0",
               bus0.acc_out, bus0.count, bus0.busy, bus0.done, bus0.ovf);
    end
    #3 rst_a = 1'b1;
    step();
    bus0.op_in = 8'd5;
    bus0.ready_in = 1'b1;
    step();
    bus0.ready_in = 1'b0;
    checks++;
    if (bus0.acc_out !== 12'd0 || bus0.count !== 3'd0 || bus0.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_rise_ignored got acc=%0d cnt=%0d busy=%b want acc=0 cnt=0 busy=0",
               bus0.acc_out, bus0.count, bus0.busy);
    end
    step();
  endtask

  task automatic test_pending_ready();
    bus0.op_in = 8'd11;
    bus0.ready_in = 1'b1;
    step();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    step();
    step();
    checks++;
    if (bus0.count !== 3'd0 || bus0.acc_out !== 12'd0 || bus0.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pending_ready got cnt=%0d acc=%0d busy=%b want cnt=0 acc=0 busy=1",
               bus0.count, bus0.acc_out, bus0.busy);
    end
    bus0.ready_in = 1'b0;
    step();
    bus0.ready_in = 1'b1;
    step();
    bus0.ready_in = 1'b0;
    checks++;
    if (bus0.count !== 3'd1 || bus0.acc_out !== 12'd11) begin
      errors++;
      $display("[TB] FAIL later_rise got cnt=%0d acc=%0d want cnt=1 acc=11", bus0.count, bus0.acc_out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      bus0.op_in = 8'd11;
      bus0.ready_in = 1'b1;
      step();
      bus0.ready_in = 1'b0;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      bus0.op_in = 8'd9;
      bus0.ready_in = 1'b1;
      step();
      bus0.ready_in = 1'b0;
      step();
    end
    checks++;
    if (bus0.acc_out !== 12'd44 || bus0.count !== 3'd4 || bus0.done !== 1'b1 || bus0.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_hold got acc=%0d cnt=%0d done=%b busy=%b want acc=44 cnt=4 done=1 busy=0",
               bus0.acc_out, bus0.count, bus0.done, bus0.busy);
    end
    bus0.start = 1'b1;
    bus0.op_in = 8'd9;
    bus0.ready_in = 1'b1;
    step();
    bus0.start = 1'b0;
    checks++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b1 || bus0.acc_out !== 12'd0 || bus0.count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL done_restart got done=%b busy=%b acc=%0d cnt=%0d want done=0 busy=1 acc=0 cnt=0",
               bus0.done, bus0.busy, bus0.acc_out, bus0.count);
    end
    step();
    checks++;
    if (bus0.count !== 3'd0 || bus0.acc_out !== 12'd0) begin
      errors++;
      $display("[TB] FAIL start_rise_ignored got cnt=%0d acc=%0d want cnt=0 acc=0", bus0.count, bus0.acc_out);
    end
    bus0.ready_in = 1'b0;
    step();
    bus0.op_in = 8'd3;
    bus0.ready_in = 1'b1;
    step();
    bus0.ready_in = 1'b0;
    checks++;
    if (bus0.count !== 3'd1 || bus0.acc_out !== 12'd3) begin
      errors++;
      $display("[TB] FAIL new_frame_first got cnt=%0d acc=%0d want cnt=1 acc=3", bus0.count, bus0.acc_out);
    end
  endtask

  // Run scenarios in order and report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_long_pulse();
    test_overflow();
    test_midframe_reset();
    test_pending_ready();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_accum.md
Name: mult_accum

Overview:
- Downstream consumer of the sequential 4x4 multiplier (`seqmult`).
- Watches the multiplier's `op`/`ready_out` pair and accumulates a frame of COUNT_N products into a running sum.
- Flags completion and sticky overflow.
- Used for dot-product / MAC style sequences built on the existing multiplier.

Parameters:
PW, 8, product input width (matches multiplier op width)
ACC_W, 12, accumulator width; sum wraps modulo 2^ACC_W
COUNT_N, 4, number of products per frame (1..2^CNT_W-1)
CNT_W, 3, width of product counter

Ports:
clk  input  1  system clock, rising-edge
rst_a  input  1  asynchronous active-low reset
op_in  input  PW  product from multiplier op
ready_in  input  1  multiplier ready_out; level, may stay high many cycles
start  input  1  begin new frame (sampled high on a clk edge)
acc_out  output  ACC_W  running accumulated sum
count  output  CNT_W  products accumulated in current frame
busy  output  1  high while in ACCUM
done  output  1  high while in DONE
ovf  output  1  sticky: carry out of ACC_W occurred this frame

Behaviour:
- Reset (rst_a=0, async, any time, including mid-frame):
  - acc_out=0, count=0, busy=0, done=0, ovf=0.
  - Internal ready_d=0, state=IDLE.
- Edge detect:
  - ready_d <= ready_in every cycle in every state.
  - rise = ready_in & ~ready_d.
  - A level held N cycles yields exactly one rise.
- States IDLE, ACCUM, DONE; all outputs registered.
- IDLE:
  - start=1 -> acc_out=0, count=0, ovf=0, busy=1, go ACCUM.
  - A rise in the same cycle as start is ignored.
  - A rise without start is ignored; outputs hold.
- ACCUM, on rise:
  - sum = acc_out + zero-extended op_in, computed at ACC_W+1 bits.
  - acc_out <= sum[ACC_W-1:0].
  - If sum[ACC_W]=1, ovf <= 1 (stays set until next start or reset).
  - count <= count+1.
  - If count == COUNT_N-1 at the rise: busy <= 0, done <= 1, go DONE.
- ACCUM, other cases:
  - start is ignored; the frame is not restarted.
  - No rise -> outputs hold.
- DONE:
  - acc_out, count (=COUNT_N), ovf and done=1 hold.
  - Further rises are ignored.
  - start=1 -> same action as start in IDLE (clear, busy=1, done=0, go ACCUM). No IDLE cycle between.
- Latency: acc_out/count/done reflect a rise on the clk edge where ready_in is first sampled high, i.e. visible in the following cycle.
- A rise already pending when entering ACCUM is not counted, because ready_d tracked ready_in through IDLE/DONE.

Test Plan:
1. Reset release, start=1 one cycle, four ready pulses with op_in=7 (a=7,b=1) -> acc_out 7,14,21,28; count 1..4; done=1 after 4th rise; busy=0; ovf=0.
2. ready_in held high 5 cycles with op_in=225, then low, repeated 4 times -> acc_out=900, count=4, each long pulse counted once, ovf=0.
3. ACC_W=8 override, COUNT_N=2: op_in 200 then 100 -> acc_out=44, ovf=1, done=1. Then start -> acc_out=0, ovf=0, busy=1.
4. Mid-frame (count=2, acc_out=50): assert start -> ignored, acc_out=50. Pull rst_a low asynchronously between clk edges -> all outputs 0 immediately. After release, rises are ignored until start.
5. ready_in already high when start asserted, falling later, then rising -> first counted rise is the later edge; count=1 only after it.
6. In DONE, extra rises with op_in=9 -> acc_out/count unchanged. start -> done=0, busy=1 on next cycle with no IDLE cycle between.
